dcache_tcm_responder: RTL
=========================

// Module: dcache_tcm_responder
// PURPOSE
//  Responder end of dcache_ports_if. Serves the LSU store port (w*) and load port (load_a_*/load_d_*)
//  from a single-port, tightly-coupled data SRAM of 64-bit words.
//  A one-entry write buffer keeps stores off the SRAM port while a load reads. Buffered bytes are
//  forwarded to loads. At most one load is outstanding, matching the LSU's single wait_load register.
// PARAMETERS
//  MEM_BYTES   65536  SRAM capacity in bytes; power of two, multiple of 8
//  INIT_FILE   ""     optional $readmemh image loaded at elaboration; "" = no init
// PORTS
//  clk               in   1   core clock
//  rst               in   1   asynchronous active-high reset
//  dcache_ports_io   if   -   dcache_ports_if, responder side; members:
//   .waddr           in   64  store physical byte address
//   .wsize           in   2   inst_size_t: 0=B 1=H 2=W 3=D
//   .wdata           in   64  store data, right-aligned (LSB = first byte)
//   .wvalid          in   1   store request
//   .wready          out  1   store accepted when wvalid&&wready at posedge
//   .load_a_addr     in   64  load physical byte address
//   .load_a_size     in   2   inst_size_t
//   .load_a_valid    in   1   load request
//   .load_a_ready    out  1   load accepted when load_a_valid&&load_a_ready at posedge
//   .load_d_data     out  64  load data, right-aligned, zero-extended (LSU sign-extends)
//   .load_d_valid    out  1   one-cycle response pulse; no back-pressure
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE, wb_valid=0, load_d_valid=0, load_d_data=0, wready=1, load_a_ready=1.
//   SRAM contents are not reset.
//  Addressing: word index = addr[$clog2(MEM_BYTES)-1:3], which wraps modulo MEM_BYTES. Byte offset = addr[2:0].
//   Low offset bits are forced to natural alignment: size H clears bit0, W clears [1:0], D clears [2:0].
//   No faults are signalled.
//  Byte enables: B=1, H=3, W=0xF, D=0xFF, each shifted left by the aligned offset.
//   Store data is shifted left by offset*8.
//  Write buffer (wb_valid, wb_idx, wb_be, wb_data):
//   - wready = !wb_valid || wb_drain.
//   - wb_drain = wb_valid && state!=READ. The drain writes the SRAM with byte enables.
//   - An accepted store loads the buffer. Accept and drain in the same cycle is legal: the old entry is
//     written and the new entry is captured.
//  Load FSM:
//   - IDLE: load_a_ready=1. On accept, latch idx/offset/size, go to READ.
//   - READ: load_a_ready=0. SRAM read of the latched idx; the SRAM port is owned by the load and no drain occurs.
//     Forwarding: if wb_valid && wb_idx==load idx, the bytes with wb_be set replace the SRAM bytes.
//     The merged word is shifted right by offset*8, masked to size, and registered. Go to RESP.
//   - RESP: load_d_valid=1 with the registered data for exactly this cycle. load_a_ready=1.
//     Accept -> READ; otherwise -> IDLE.
//  Latency: load accepted at edge T -> load_d_valid high in cycle T+2.
//   Maximum load throughput is one per 2 cycles. Store throughput is 1/cycle when no load is in READ.
//  Ordering:
//   - A store and a load accepted at the same edge: the store is older and its bytes are visible to the load.
//   - A store accepted while a load is in READ is not visible to that load.
//  load_d_data holds its last value when load_d_valid=0. It is cleared only by reset.
//  Reset mid-operation: an in-flight load is dropped (no load_d_valid) and the buffered store is lost.
//   The LSU is reset together with this block.
//  Simultaneous wvalid with wb full and state==READ: wready=0; the store is accepted on the next cycle.
// TESTING
//  1 Store D 0x1122334455667788 @0x10, later load D @0x10 accepted at T -> load_d_valid@T+2,
//    data 0x1122334455667788.
//  2 After test 1: store B 0xAB @0x13, then load W @0x10 -> 0x00000000AB667788.
//    Load H @0x13 -> 0xAB66 (aligned to 0x12).
//  3 Store W 0xDEADBEEF @0x20 and load W @0x20 on the same edge -> forwarded 0xDEADBEEF at T+2.
//    SRAM written afterwards.
//  4 load_a_valid held high with addrs 0x10, 0x18: load_a_ready=0 in T+1.
//    Second load accepted at T+2; load_d_valid at T+2 and T+4 only.
//  5 Stores on every cycle while a load occupies READ: wready drops for exactly that cycle.
//    All stores land; a read-back of each address matches.
//  6 Assert rst during READ: load_d_valid stays 0; load_a_ready=1 and wready=1 immediately.
//    A new load after release returns at T+2.

Source files
------------

// File: rtl/dcache_ports_if.sv
// LSU <-> data TCM port bundle: one store channel and one request/response load channel.
interface dcache_ports_if;
    logic [63:0] waddr;
    logic [1:0]  wsize;
    logic [63:0] wdata;
    logic        wvalid;
    logic        wready;
    logic [63:0] load_a_addr;
    logic [1:0]  load_a_size;
    logic        load_a_valid;
    logic        load_a_ready;
    logic [63:0] load_d_data;
    logic        load_d_valid;

    modport responder (
        input  waddr, wsize, wdata, wvalid, load_a_addr, load_a_size, load_a_valid,
        output wready, load_a_ready, load_d_data, load_d_valid
    );

    modport requester (
        output waddr, wsize, wdata, wvalid, load_a_addr, load_a_size, load_a_valid,
        input  wready, load_a_ready, load_d_data, load_d_valid
    );
endinterface

// File: rtl/dcache_tcm_responder.sv
// Data TCM responder: single-port 64-bit SRAM, one-entry store buffer with load forwarding,
// and a single-outstanding load FSM (request -> READ -> RESP).
module dcache_tcm_responder #(
  parameter int unsigned MEM_BYTES = 65536,
  parameter string       INIT_FILE = ""
) (
  input logic               clk,
  input logic               rst,
  dcache_ports_if.responder dcache_ports_io
);
  localparam int unsigned AW    = $clog2(MEM_BYTES);
  localparam int unsigned IW    = AW - 3;
  localparam int unsigned WORDS = MEM_BYTES / 8;

  typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

  state_t        state, state_next;
  logic [63:0]   mem [WORDS];

  logic          wb_valid;
  logic [IW-1:0] wb_idx;
  logic [7:0]    wb_be;
  logic [63:0]   wb_data;
  logic          wb_drain;
  logic          store_acc;

  logic [IW-1:0] ld_idx;
  logic [2:0]    ld_off;
  logic [1:0]    ld_size;
  logic [63:0]   ld_data;
  logic          load_acc;
  logic          load_a_ready;
  logic          load_d_valid;

  logic [2:0]    st_off;
  logic [63:0]   merged;
  logic [63:0]   load_word;
  logic          unused_addr;

  function automatic logic [2:0] align_off(input logic [2:0] a, input logic [1:0] size);
    case (size)
      2'd1:    return {a[2:1], 1'b0};
      2'd2:    return {a[2], 2'b00};
      2'd3:    return 3'b000;
      default: return a;
    endcase
  endfunction

  function automatic logic [7:0] size_be(input logic [1:0] size);
    case (size)
      2'd1:    return 8'h03;
      2'd2:    return 8'h0F;
      2'd3:    return 8'hFF;
      default: return 8'h01;
    endcase
  endfunction

  function automatic logic [63:0] size_mask(input logic [1:0] size);
    case (size)
      2'd1:    return 64'h0000_0000_0000_FFFF;
      2'd2:    return 64'h0000_0000_FFFF_FFFF;
      2'd3:    return '1;
      default: return 64'h0000_0000_0000_00FF;
    endcase
  endfunction

  assign unused_addr = ^{dcache_ports_io.waddr[63:AW], dcache_ports_io.load_a_addr[63:AW]};

  // Store path: the SRAM port belongs to the load while in READ, so the buffer only drains outside it.
  assign st_off    = align_off(dcache_ports_io.waddr[2:0], dcache_ports_io.wsize);
  assign wb_drain  = wb_valid && (state != READ);
  assign dcache_ports_io.wready = !wb_valid || wb_drain;
  assign store_acc = dcache_ports_io.wvalid && dcache_ports_io.wready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_idx   <= '0;
      wb_be    <= '0;
      wb_data  <= '0;
    end else if (store_acc) begin
      wb_valid <= 1'b1;
      wb_idx   <= dcache_ports_io.waddr[AW-1:3];
      wb_be    <= size_be(dcache_ports_io.wsize) << st_off;
      wb_data  <= dcache_ports_io.wdata << {st_off, 3'b000};
    end else if (wb_drain) begin
      wb_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wb_drain) begin
      for (int unsigned b = 0; b < 8; b++) begin
        if (wb_be[b]) begin
          mem[wb_idx][b*8 +: 8] <= wb_data[b*8 +: 8];
        end
      end
    end
  end

  // Buffered bytes are newer than the SRAM copy, so they win on an index match.
  always_comb begin
    merged = mem[ld_idx];
    for (int unsigned b = 0; b < 8; b++) begin
      if (wb_valid && (wb_idx == ld_idx) && wb_be[b]) begin
        merged[b*8 +: 8] = wb_data[b*8 +: 8];
      end
    end
    load_word = (merged >> {ld_off, 3'b000}) & size_mask(ld_size);
  end

  assign load_acc = dcache_ports_io.load_a_valid && load_a_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ld_idx  <= '0;
      ld_off  <= '0;
      ld_size <= '0;
      ld_data <= '0;
    end else begin
      state <= state_next;
      if (load_acc) begin
        ld_idx  <= dcache_ports_io.load_a_addr[AW-1:3];
        ld_off  <= align_off(dcache_ports_io.load_a_addr[2:0], dcache_ports_io.load_a_size);
        ld_size <= dcache_ports_io.load_a_size;
      end
      if (state == READ) begin
        ld_data <= load_word;
      end
    end
  end

  always_comb begin
    state_next   = state;
    load_a_ready = 1'b0;
    load_d_valid = 1'b0;
    case (state)
      IDLE: begin
        load_a_ready = 1'b1;
        if (dcache_ports_io.load_a_valid) state_next = READ;
      end
      READ: begin
        state_next = RESP;
      end
      RESP: begin
        load_a_ready = 1'b1;
        load_d_valid = 1'b1;
        state_next   = dcache_ports_io.load_a_valid ? READ : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign dcache_ports_io.load_a_ready = load_a_ready;
  assign dcache_ports_io.load_d_valid = load_d_valid;
  assign dcache_ports_io.load_d_data  = ld_data;
endmodule
